// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: scan-strobe prescaler plus multi-digit BCD entry
// collector for a 3x4 keypad scanner, with backspace (*), enter (#) and a
// valid/ready hand-off of the completed entry.
module keypad_entry_ctrl #(
  parameter int unsigned SCAN_DIV = 12,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  scan_en,
  input  logic [9:0]            numbers,
  input  logic                  asterisk,
  input  logic                  hash,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic [3:0]            entry_len,
  output logic                  entry_valid,
  input  logic                  entry_ready,
  output logic                  key_pulse,
  output logic                  overflow
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_OFFER   = 1'b1;

  logic [15:0]          r_cnt;
  logic                 r_scan_en;
  logic [11:0]          r_prev;
  logic [0:0]           r_state;
  logic [4*DIGITS-1:0]  r_bcd;
  logic [3:0]           r_len;
  logic                 r_valid;
  logic                 r_key_pulse;
  logic                 r_overflow;

  logic [11:0]          w_keys;
  logic                 w_press;
  logic                 w_is_digit;
  logic [3:0]           w_digit;
  logic [4*DIGITS-1:0]  w_shl;
  logic [4*DIGITS-1:0]  w_shr;

  // Free-running scan prescaler; strobe is registered off the wrap count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_scan_en <= 1'b0;
    end else if (r_cnt == 16'(SCAN_DIV - 1)) begin
      r_cnt     <= '0;
      r_scan_en <= 1'b1;
    end else begin
      r_cnt     <= r_cnt + 16'd1;
      r_scan_en <= 1'b0;
    end
  end

  // Press detection: exactly one key high and that key was low last cycle
  always_comb begin
    w_keys     = {hash, asterisk, numbers};
    w_press    = $onehot(w_keys) && ((w_keys & ~r_prev) != '0);
    w_is_digit = |numbers;
    w_digit    = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (numbers[i]) w_digit = 4'(i);
    end
    w_shl = (r_bcd << 4) | (4*DIGITS)'(w_digit);
    w_shr = r_bcd >> 4;
  end

  // Entry state machine: collect digits, then hold the entry until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '1;
      r_state     <= ST_COLLECT;
      r_bcd       <= '0;
      r_len       <= '0;
      r_valid     <= 1'b0;
      r_key_pulse <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_prev      <= w_keys;
      r_key_pulse <= 1'b0;
      r_overflow  <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_press) begin
            if (w_is_digit) begin
              r_key_pulse <= 1'b1;
              if (r_len < 4'(DIGITS)) begin
                r_bcd <= w_shl;
                r_len <= r_len + 4'd1;
              end else begin
                r_overflow <= 1'b1;
              end
            end else if (asterisk) begin
              if (r_len != '0) begin
                r_bcd       <= w_shr;
                r_len       <= r_len - 4'd1;
                r_key_pulse <= 1'b1;
              end
            end else begin
              if (r_len != '0) begin
                r_state     <= ST_OFFER;
                r_valid     <= 1'b1;
                r_key_pulse <= 1'b1;
              end
            end
          end
        end
        ST_OFFER: begin
          if (r_valid && entry_ready) begin
            r_state <= ST_COLLECT;
            r_bcd   <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign scan_en     = r_scan_en;
  assign entry_bcd   = r_bcd;
  assign entry_len   = r_len;
  assign entry_valid = r_valid;
  assign key_pulse   = r_key_pulse;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: directed plan steps followed by random
// key/ready traffic, all checked against a queue-based entry model.
module tb_keypad_entry_ctrl;

  localparam int unsigned SCAN_DIV = 12;
  localparam int unsigned DIGITS   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                scan_en;
  logic [9:0]          numbers = '0;
  logic                asterisk = 1'b0;
  logic                hash = 1'b0;
  logic [4*DIGITS-1:0] entry_bcd;
  logic [3:0]          entry_len;
  logic                entry_valid;
  logic                entry_ready = 1'b0;
  logic                key_pulse;
  logic                overflow;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state
  int         q[$];
  bit         m_offer;
  bit [11:0]  m_prev;
  bit         m_pulse;
  bit         m_ovf;
  int unsigned ncyc;

  keypad_entry_ctrl #(.SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .numbers(numbers), .asterisk(asterisk), .hash(hash),
    .entry_bcd(entry_bcd), .entry_len(entry_len), .entry_valid(entry_valid),
    .entry_ready(entry_ready), .key_pulse(key_pulse), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] K(input int unsigned i);
    logic [11:0] one;
    one = 12'd1;
    return one << i;
  endfunction

  function automatic logic [31:0] m_bcd();
    logic [31:0] v;
    v = 0;
    foreach (q[j]) v = v * 16 + q[j];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_offer = 0;
    m_prev  = '1;
    m_pulse = 0;
    m_ovf   = 0;
    ncyc    = 0;
  endtask

  // Apply one edge worth of key levels / ready following the entry rules
  task automatic model_step(input bit [11:0] k, input bit rdy);
    int idx;
    m_pulse = 0;
    m_ovf   = 0;
    if (m_offer) begin
      if (rdy) begin
        q.delete();
        m_offer = 0;
      end
    end else if ($countones(k) == 1 && (k & ~m_prev) != 0) begin
      idx = 0;
      for (int i = 0; i < 12; i++) if (k[i]) idx = i;
      if (idx < 10) begin
        m_pulse = 1;
        if (q.size() < DIGITS) q.push_back(idx);
        else m_ovf = 1;
      end else if (idx == 10) begin
        if (q.size() > 0) begin
          void'(q.pop_back());
          m_pulse = 1;
        end
      end else begin
        if (q.size() > 0) begin
          m_offer = 1;
          m_pulse = 1;
        end
      end
    end
    m_prev = k;
    ncyc++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bcd"},   32'(entry_bcd),   m_bcd());
    chk({tag, ".len"},   32'(entry_len),   32'(q.size()));
    chk({tag, ".valid"}, 32'(entry_valid), 32'(m_offer));
    chk({tag, ".pulse"}, 32'(key_pulse),   32'(m_pulse));
    chk({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
    chk({tag, ".scan"},  32'(scan_en),     32'((ncyc % SCAN_DIV) == 0));
  endtask

  // Starts and ends at a falling edge; drives levels over one rising edge
  task automatic step(input logic [11:0] k, input logic rdy, input string tag);
    {hash, asterisk, numbers} = k;
    entry_ready = rdy;
    model_step(k, rdy);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic tap(input int unsigned i, input string tag);
    step(K(i), 1'b0, tag);
    step('0, 1'b0, {tag, ".rel"});
  endtask

  initial begin
    model_reset();
    numbers[4] = 1'b1;
    @(negedge clk);
    chk("rst.bcd", 32'(entry_bcd), 0);
    chk("rst.len", 32'(entry_len), 0);
    chk("rst.valid", 32'(entry_valid), 0);
    chk("rst.pulse", 32'(key_pulse), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.scan", 32'(scan_en), 0);
    rst = 1'b0;

    // Key 4 held across reset release is ignored until re-pressed
    for (int i = 0; i < 3; i++) step(K(4), 1'b0, "hold4");
    chk("hold4.len", 32'(entry_len), 0);
    step('0, 1'b0, "rel4");
    step(K(4), 1'b0, "press4");
    chk("press4.len", 32'(entry_len), 1);
    chk("press4.pulse", 32'(key_pulse), 1);
    step('0, 1'b0, "rel4b");
    tap(10, "bs4");

    // Entry 1,2,3,# then a held-off offer with lockout
    tap(1, "d1"); tap(2, "d2"); tap(3, "d3");
    step(K(11), 1'b0, "enter");
    chk("enter.bcd", 32'(entry_bcd), 32'h0123);
    chk("enter.len", 32'(entry_len), 3);
    chk("enter.valid", 32'(entry_valid), 1);
    for (int i = 0; i < 5; i++) step('0, 1'b0, "offer_wait");
    step(K(3), 1'b0, "lock3");
    chk("lock3.pulse", 32'(key_pulse), 0);
    step('0, 1'b0, "lock_rel");
    step(K(10), 1'b0, "lockbs");
    chk("lockbs.bcd", 32'(entry_bcd), 32'h0123);
    step('0, 1'b0, "lock_rel2");
    step(K(5), 1'b1, "handshake");
    chk("hs.valid", 32'(entry_valid), 0);
    chk("hs.len", 32'(entry_len), 0);
    chk("hs.bcd", 32'(entry_bcd), 0);
    chk("hs.pulse", 32'(key_pulse), 0);
    step(K(7), 1'b0, "after_hs");
    chk("after_hs.bcd", 32'(entry_bcd), 32'h0007);
    step('0, 1'b0, "after_hs_rel");
    tap(10, "bs7");

    // Backspace and full entry
    tap(9, "d9"); tap(8, "d8"); tap(10, "bs8");
    chk("bs8.bcd", 32'(entry_bcd), 32'h0009);
    tap(7, "d7"); tap(6, "d6"); tap(5, "d5");
    chk("full.bcd", 32'(entry_bcd), 32'h9765);
    chk("full.len", 32'(entry_len), 4);
    step(K(4), 1'b0, "ovf4");
    chk("ovf4.ovf", 32'(overflow), 1);
    chk("ovf4.bcd", 32'(entry_bcd), 32'h9765);
    step('0, 1'b0, "ovf4_rel");
    for (int i = 0; i < 4; i++) tap(10, "clear");
    step(K(10), 1'b0, "bs_empty");
    chk("bs_empty.pulse", 32'(key_pulse), 0);
    step('0, 1'b0, "bs_empty_rel");
    step(K(11), 1'b0, "enter_empty");
    chk("enter_empty.pulse", 32'(key_pulse), 0);
    chk("enter_empty.valid", 32'(entry_valid), 0);
    step('0, 1'b0, "enter_empty_rel");

    // Rollover lockout
    step(K(5), 1'b0, "roll5");
    step(K(5) | K(6), 1'b0, "roll56");
    step(K(6), 1'b0, "roll6held");
    chk("roll.len", 32'(entry_len), 1);
    step('0, 1'b0, "roll_rel");
    step(K(6), 1'b0, "roll6");
    chk("roll6.bcd", 32'(entry_bcd), 32'h0056);
    step('0, 1'b0, "roll6_rel");

    // Reset mid-offer clears asynchronously
    step(K(11), 1'b0, "offer2");
    step('0, 1'b0, "offer2_rel");
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(entry_valid), 0);
    chk("arst.len", 32'(entry_len), 0);
    chk("arst.bcd", 32'(entry_bcd), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model
    begin
      logic [11:0] k;
      int unsigned r;
      k = '0;
      for (int n = 0; n < 800; n++) begin
        r = $urandom_range(0, 9);
        if (r < 4) k = '0;
        else if (r < 8) k = K($urandom_range(0, 11));
        else if (r == 8) k = K($urandom_range(0, 11)) | K($urandom_range(0, 11));
        step(k, 1'($urandom_range(0, 3) == 0), "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
